// File: rtl/var_delay_shifter_if.sv
// Signal bundle for var_delay_shifter: word input handshake, tap controls and status.
// The bench drives the master side; the delay line sits on the slave side.
interface var_delay_shifter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int NTAPS = 2
);
  localparam int SELW  = $clog2(DEPTH);
  localparam int FILLW = $clog2(DEPTH + 1);

  logic                   clear_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   mode;
  logic [NTAPS*SELW-1:0]  sel;
  logic                   flush;
  logic [NTAPS*WIDTH-1:0] tap_data;
  logic [NTAPS-1:0]       tap_valid;
  logic [NTAPS-1:0]       sel_err;
  logic [FILLW-1:0]       fill_level;
  logic                   full;
  logic                   flush_done;

  modport master (
    output clear_n, in_valid, in_data, mode, sel, flush,
    input  in_ready, tap_data, tap_valid, sel_err, fill_level, full, flush_done
  );

  modport slave (
    input  clear_n, in_valid, in_data, mode, sel, flush,
    output in_ready, tap_data, tap_valid, sel_err, fill_level, full, flush_done
  );
endinterface

// File: rtl/var_delay_shifter.sv
// Multi-tap variable-depth word delay line with per-stage valid bits,
// fill accounting, a flush sequencer and registered tap read ports.
module var_delay_shifter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int NTAPS = 2
) (
  input logic                clock,
  input logic                reset,
  var_delay_shifter_if.slave bus
);
  localparam int SELW  = $clog2(DEPTH);
  localparam int FILLW = $clog2(DEPTH + 1);
  localparam logic [SELW-1:0]  LAST_SEL  = SELW'(DEPTH - 1);
  localparam logic [SELW:0]    DEPTH_EXT = (SELW + 1)'(DEPTH);
  localparam logic [FILLW-1:0] FILL_FULL = FILLW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       stage_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [FILLW-1:0]       fill_q, fill_d;
  logic [NTAPS*WIDTH-1:0] tapData_q, tapData_d;
  logic [NTAPS-1:0]       tapValid_q, tapValid_d;
  logic [NTAPS-1:0]       selErr_q, selErr_d;
  logic                   flushDone_q;
  logic [SELW-1:0]        tapIdx [NTAPS];
  logic                   accept;
  logic                   doShift;

  // A flush drains by shifting bubbles in every cycle, so input is refused meanwhile.
  assign accept  = bus.in_valid && (state_q != FLUSH);
  assign doShift = accept || (state_q == FLUSH);

  always_comb begin
    fill_d = fill_q;
    if (doShift) begin
      fill_d = fill_q + FILLW'(accept) - FILLW'(valid_q[DEPTH-1]);
    end
  end

  // Out-of-range selects (only possible for non-power-of-2 DEPTH) clamp to the last stage.
  always_comb begin
    tapIdx     = '{default: LAST_SEL};
    tapData_d  = '0;
    tapValid_d = '0;
    selErr_d   = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (bus.mode) begin
        if ({1'b0, bus.sel[k*SELW +: SELW]} >= DEPTH_EXT) begin
          selErr_d[k] = 1'b1;
        end else begin
          tapIdx[k] = bus.sel[k*SELW +: SELW];
        end
      end
      tapData_d[k*WIDTH +: WIDTH] = stage_q[tapIdx[k]];
      tapValid_d[k]               = valid_q[tapIdx[k]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fill_q      <= '0;
      tapData_q   <= '0;
      tapValid_q  <= '0;
      selErr_q    <= '0;
      flushDone_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (!bus.clear_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fill_q      <= '0;
      tapData_q   <= '0;
      tapValid_q  <= '0;
      selErr_q    <= '0;
      flushDone_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      if (doShift) begin
        for (int i = DEPTH - 1; i > 0; i--) stage_q[i] <= stage_q[i-1];
        stage_q[0] <= accept ? bus.in_data : '0;
        valid_q    <= {valid_q[DEPTH-2:0], accept};
      end
      fill_q      <= fill_d;
      tapData_q   <= tapData_d;
      tapValid_q  <= tapValid_d;
      selErr_q    <= selErr_d;
      flushDone_q <= 1'b0;
      // A flush request on an empty line with nothing arriving completes at once.
      case (state_q)
        FLUSH: begin
          if (fill_d == '0) begin
            state_q     <= IDLE;
            flushDone_q <= 1'b1;
          end
        end
        default: begin
          if (bus.flush && (fill_d != '0)) begin
            state_q <= FLUSH;
          end else if (bus.flush) begin
            state_q     <= IDLE;
            flushDone_q <= 1'b1;
          end else begin
            state_q <= (fill_d == '0) ? IDLE : RUN;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_q != FLUSH);
  assign bus.tap_data   = tapData_q;
  assign bus.tap_valid  = tapValid_q;
  assign bus.sel_err    = selErr_q;
  assign bus.fill_level = fill_q;
  assign bus.full       = (fill_q == FILL_FULL);
  assign bus.flush_done = flushDone_q;
endmodule

// File: tb/tb_var_delay_shifter.sv
// Scoreboarded bench for var_delay_shifter: directed stimulus queues hand-computed
// expectations tagged with the cycle they are due; a negedge monitor checks them.
module tb_var_delay_shifter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int NTAPS = 2;

  typedef enum int {K_TAP0, K_TAP1, K_TV0, K_TV1, K_FILL, K_FULL, K_READY, K_FDONE, K_ERR} kind_t;

  typedef struct {
    string       name;
    int          due;
    kind_t       kind;
    logic [31:0] value;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  exp_t expQ[$];
  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;

  var_delay_shifter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NTAPS(NTAPS)) bus ();

  var_delay_shifter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NTAPS(NTAPS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic expectAt(input string name, input kind_t kind, input int delay, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.due   = cyc + delay;
    e.kind  = kind;
    e.value = value;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] actualOf(input kind_t kind);
    case (kind)
      K_TAP0:  return 32'(bus.tap_data[7:0]);
      K_TAP1:  return 32'(bus.tap_data[15:8]);
      K_TV0:   return 32'(bus.tap_valid[0]);
      K_TV1:   return 32'(bus.tap_valid[1]);
      K_FILL:  return 32'(bus.fill_level);
      K_FULL:  return 32'(bus.full);
      K_READY: return 32'(bus.in_ready);
      K_FDONE: return 32'(bus.flush_done);
      default: return 32'(bus.sel_err);
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    act = actualOf(e.kind);
    assertCount++;
    if (e.due != cyc) begin
      failCount++;
      $display("[TB] FAIL %s: checked at cycle %0d but due at cycle %0d", e.name, cyc, e.due);
    end else if (act !== e.value) begin
      failCount++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, act, e.value);
    end
  endtask

  // Monitor: pop every expectation that has come due and compare it.
  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < expQ.size()) begin
      if (expQ[i].due <= cyc) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic flush, input logic clearN);
    bus.in_valid = valid;
    bus.in_data  = data;
    bus.flush    = flush;
    bus.clear_n  = clearN;
    @(negedge clock);
  endtask

  initial begin
    bus.clear_n  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 1'b0;
    bus.sel      = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Reset state
    expectAt("rst fill", K_FILL, 1, 0);
    expectAt("rst full", K_FULL, 1, 0);
    expectAt("rst ready", K_READY, 1, 1);
    expectAt("rst fdone", K_FDONE, 1, 0);
    expectAt("rst tap0", K_TAP0, 1, 0);
    expectAt("rst tv0", K_TV0, 1, 0);
    expectAt("rst tv1", K_TV1, 1, 0);
    expectAt("rst err", K_ERR, 1, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // A1..A5 with tap0 on stage 0 and tap1 on stage 4
    bus.mode = 1'b1;
    bus.sel  = {5'd4, 5'd0};
    for (int i = 1; i <= 5; i++) begin
      expectAt("s1 fill", K_FILL, 1, 32'(i));
      expectAt("s1 tap0", K_TAP0, 2, 32'(8'hA0 + i));
      if (i == 5) begin
        expectAt("s1 tv1 before A1 arrives", K_TV1, 1, 0);
        expectAt("s1 tap1 A1", K_TAP1, 2, 32'h0A1);
        expectAt("s1 tv1", K_TV1, 2, 1);
        expectAt("s1 fill hold", K_FILL, 2, 5);
        expectAt("s1 ready", K_READY, 2, 1);
      end
      applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    expectAt("clear fill", K_FILL, 1, 0);
    expectAt("clear tv0", K_TV0, 1, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // 34 words through a 32-deep line, taps on the last stage
    bus.mode = 1'b0;
    bus.sel  = '0;
    for (int j = 0; j < 34; j++) begin
      expectAt("s2 fill", K_FILL, 1, 32'((j + 1 > DEPTH) ? DEPTH : j + 1));
      expectAt("s2 full", K_FULL, 1, 32'(j >= 31));
      if (j == 0) expectAt("s2 sel_err", K_ERR, 1, 0);
      if (j == 30) expectAt("s2 tv0 not yet", K_TV0, 2, 0);
      if (j >= 31) begin
        expectAt("s2 tap0", K_TAP0, 2, 32'(j - 31));
        expectAt("s2 tap1", K_TAP1, 2, 32'(j - 31));
        expectAt("s2 tv0", K_TV0, 2, 1);
      end
      applyStimulus(1'b1, 8'(j), 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush with a word offered in the same cycle
    bus.mode = 1'b1;
    bus.sel  = {5'd2, 5'd0};
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1);
    expectAt("s3 fill after flush req", K_FILL, 1, 4);
    expectAt("s3 ready drops", K_READY, 1, 0);
    expectAt("s3 fdone early", K_FDONE, 1, 0);
    expectAt("s3 tap1 B2", K_TAP1, 2, 32'h0B2);
    expectAt("s3 tv1", K_TV1, 2, 1);
    applyStimulus(1'b1, 8'hB4, 1'b1, 1'b1);
    for (int n = 1; n <= 33; n++) begin
      expectAt("s3 fill drain", K_FILL, 1, 32'((n <= 28) ? 4 : ((n <= 32) ? 32 - n : 0)));
      expectAt("s3 ready", K_READY, 1, 32'(n >= 32));
      expectAt("s3 fdone", K_FDONE, 1, 32'(n == 32));
      applyStimulus(n <= 32, 8'hEE, 1'b0, 1'b1);
    end

    // Flush on an empty line
    expectAt("s4 fdone pulse", K_FDONE, 1, 1);
    expectAt("s4 ready", K_READY, 1, 1);
    expectAt("s4 fill", K_FILL, 1, 0);
    expectAt("s4 tv0", K_TV0, 1, 0);
    expectAt("s4 fdone end", K_FDONE, 2, 0);
    expectAt("s4 ready after", K_READY, 2, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Clear in the middle of a flush, with a word offered
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b1);
    expectAt("s5 in flush", K_READY, 1, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    expectAt("s5 clear fill", K_FILL, 1, 0);
    expectAt("s5 clear ready", K_READY, 1, 1);
    expectAt("s5 clear fdone", K_FDONE, 1, 0);
    expectAt("s5 clear tv0", K_TV0, 1, 0);
    expectAt("s5 clear tv1", K_TV1, 1, 0);
    expectAt("s5 clear tap0", K_TAP0, 1, 0);
    expectAt("s5 clear tap1", K_TAP1, 1, 0);
    expectAt("s5 fill after", K_FILL, 2, 0);
    expectAt("s5 fdone after", K_FDONE, 2, 0);
    expectAt("s5 ready after", K_READY, 2, 1);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset between edges
    bus.sel = {5'd1, 5'd0};
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    expectAt("s6 async fill", K_FILL, 0, 0);
    expectAt("s6 async tv0", K_TV0, 0, 0);
    expectAt("s6 async tap0", K_TAP0, 0, 0);
    expectAt("s6 async tv1", K_TV1, 0, 0);
    expectAt("s6 async ready", K_READY, 0, 1);
    expectAt("s6 async full", K_FULL, 0, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    repeat (4) @(negedge clock);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: never checked (due cycle %0d, now %0d)", e.name, e.due, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
